tap_tempo_blinker: RTL and testbench
====================================

// Module: tap_tempo_blinker
// PURPOSE
//  Parametrised tap-tempo LED blinker: the user taps a button and the block measures the interval between taps.
//  It blinks an output at that period, with programmable duty cycle and phase locked to the last tap.
//  Sits between a raw board button input (usr_btn_b class) and an RGB LED channel in top-level designs.
//  Successor to the single-capture blinker: adds synchroniser, proper debounce, interval limits, averaging, duty control.
// PARAMETERS
//  CNT_W          32        width of interval/phase counters and period register
//  DEBOUNCE_CYC   48000     cycles the synchronised input must be stable before debounced state changes
//  DEFAULT_PERIOD 48000000  period loaded at reset (1 Hz at 48 MHz); must be >= MIN_PERIOD
//  MIN_PERIOD     4800000   taps closer than this (cycles) are ignored (10 Hz max at 48 MHz)
//  MAX_PERIOD     192000000 interval counter limit; no tap within this -> timeout (must be < 2**CNT_W)
//  AVG_LOG2       2         averaging window = 2**AVG_LOG2 intervals (only with TAP_AVG_EN)
//  DUTY_W         8         width of duty input; duty fraction = duty / 2**DUTY_W
// PORTS
//  clk48        in   1         system clock, all logic rising-edge
//  rst_n        in   1         asynchronous, active-low reset
//  btn_in       in   1         raw button, asynchronous to clk48, active high
//  duty         in   DUTY_W    LED on-fraction; sampled every cycle
//  led_out      out  1         blink output, active high
//  tap_pulse    out  1         1-cycle pulse on every accepted tap
//  period_out   out  CNT_W     period currently in use (cycles)
//  period_valid out  1         1 once a period has been measured since reset; 0 while DEFAULT_PERIOD is in use
//  timeout      out  1         1-cycle pulse when the ARMED interval reaches MAX_PERIOD
// BEHAVIOUR
//  Reset values: led_out=0, tap_pulse=0, period_out=DEFAULT_PERIOD, period_valid=0, timeout=0, FSM=IDLE, counters=0.
//  Input path: 2-FF synchroniser; debounced state toggles only after DEBOUNCE_CYC consecutive cycles of differing sync value.
//  Tap = rising edge of debounced state; total latency from btn_in edge to internal tap = DEBOUNCE_CYC+3 cycles.
//  FSM IDLE: interval counter held at 0. Tap -> ARMED, tap_pulse=1, phase counter restarts at 0; period unchanged.
//  FSM ARMED: interval counter increments from 1 each cycle; it holds the number of cycles since the last accepted tap.
//   - tap and interval < MIN_PERIOD: ignored; no pulse, counter keeps running.
//   - tap and MIN_PERIOD <= interval < MAX_PERIOD: accepted; tap_pulse=1; interval written to the period path.
//     Interval counter restarts at 1 and phase restarts at 0. period_out updates 2 cycles after the tap; period_valid<=1.
//   - interval reaches MAX_PERIOD with no tap: timeout=1 for one cycle, go to IDLE.
//     period_out, period_valid and the blinking continue unchanged.
//   - tap and timeout in the same cycle: the tap wins (accepted), no timeout pulse.
//  Blinker: phase counter runs 0..period_out-1 and wraps; it also restarts on an accepted tap or on any period_out change.
//   threshold = (period_out * duty) >> DUTY_W, computed at CNT_W+DUTY_W bits and registered (1-cycle latency).
//   led_out = (phase < threshold), registered. duty=0 -> constant 0; duty max -> on for all but period/2**DUTY_W cycles.
//  Reset mid-operation: all state returns to reset values immediately (async); the averaging window is cleared.
// CONFIGURATION
//  TAP_AVG_EN defined: accepted intervals enter a 2**AVG_LOG2-entry window with a running sum of CNT_W+AVG_LOG2 bits.
//   period = sum >> AVG_LOG2. The first accepted interval after reset or after a timeout fills every entry,
//   so period equals that interval immediately. Subsequent intervals replace the oldest entry.
//  TAP_AVG_EN undefined: period = last accepted interval. No window storage; AVG_LOG2 is unused. Same latency.
// TESTING (sim params: DEBOUNCE_CYC=4, MIN_PERIOD=16, MAX_PERIOD=200, DEFAULT_PERIOD=100, DUTY_W=8)
//  Reset, duty=128, no taps -> led_out high 50 cycles, low 50, repeating; period_out=100; period_valid=0.
//  btn_in glitch high for 3 cycles -> no tap_pulse; debounced state unchanged.
//  Taps 40 cycles apart (two taps) -> second tap_pulse; period_out=40 two cycles later; period_valid=1; led phase restarts.
//  Taps 10 cycles apart after ARMED -> second tap ignored; no tap_pulse; period unchanged.
//  One tap then no tap for 200 cycles -> timeout pulse at interval 200; FSM IDLE; period_out retained.
//  TAP_AVG_EN, AVG_LOG2=2: intervals 40,40,40,40,80 -> period_out 40,40,40,40,50; duty=0 -> led_out stays 0.

Source files
------------

// File: rtl/tap_tempo_blinker.sv
// Tap-tempo blinker: measures the interval between button taps and blinks
// led_out at that period with duty-controlled on-time, phase locked to taps.
// Ports: clk48, rst_n (async, active low), btn_in (raw button), duty;
//   led_out, tap_pulse, period_out, period_valid, timeout.
// Define TAP_AVG_EN to average the last 2**AVG_LOG2 accepted intervals.
module tap_tempo_blinker #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEBOUNCE_CYC   = 48000,
  parameter int unsigned DEFAULT_PERIOD = 48000000,
  parameter int unsigned MIN_PERIOD     = 4800000,
  parameter int unsigned MAX_PERIOD     = 192000000,
  parameter int unsigned AVG_LOG2       = 2,
  parameter int unsigned DUTY_W         = 8
) (
  input  logic              clk48,
  input  logic              rst_n,
  input  logic              btn_in,
  input  logic [DUTY_W-1:0] duty,
  output logic              led_out,
  output logic              tap_pulse,
  output logic [CNT_W-1:0]  period_out,
  output logic              period_valid,
  output logic              timeout
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);
  localparam int unsigned PW = CNT_W + DUTY_W;

  typedef enum logic {
    IDLE,
    ARMED
  } state_t;

  logic sync1_q, sync2_q;
  logic deb_q, deb_d, deb_prev_q;
  logic tap_q, tap_d;
  logic [DB_W-1:0] deb_cnt_q, deb_cnt_d;
  state_t state_q, state_d;
  logic [CNT_W-1:0] int_cnt_q, int_cnt_d;
  logic acc, meas;
  logic tap_pulse_q, timeout_q, timeout_d;
  logic upd_q, valid_q, valid_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0] new_period;
  logic led_q, led_d;

  // Debounce: flip only after DEBOUNCE_CYC consecutive differing samples
  always_comb begin
    deb_d = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
    tap_d = deb_q & ~deb_prev_q;
  end

  always_comb begin
    state_d = state_q;
    int_cnt_d = int_cnt_q;
    acc = 1'b0;
    meas = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        int_cnt_d = '0;
        if (tap_q) begin
          state_d = ARMED;
          int_cnt_d = CNT_W'(1);
          acc = 1'b1;
        end
      end
      ARMED: begin
        // A tap landing on the MAX_PERIOD cycle beats the timeout
        if (tap_q && int_cnt_q >= MIN_P) begin
          acc = 1'b1;
          meas = 1'b1;
          int_cnt_d = CNT_W'(1);
        end else if (int_cnt_q >= MAX_P) begin
          timeout_d = 1'b1;
          state_d = IDLE;
          int_cnt_d = '0;
        end else begin
          int_cnt_d = int_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef TAP_AVG_EN
  localparam int unsigned WIN = 1 << AVG_LOG2;
  localparam int unsigned SW = CNT_W + AVG_LOG2;

  logic [WIN-1:0][CNT_W-1:0] win_q, win_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [AVG_LOG2-1:0] ptr_q, ptr_d;
  logic fill_q, fill_d;

  // First interval after reset/timeout seeds the whole window
  always_comb begin
    win_d = win_q;
    sum_d = sum_q;
    ptr_d = ptr_q;
    fill_d = fill_q;
    if (meas) begin
      if (fill_q) begin
        for (int i = 0; i < WIN; i++) win_d[i] = int_cnt_q;
        sum_d = SW'(int_cnt_q) << AVG_LOG2;
        ptr_d = '0;
        fill_d = 1'b0;
      end else begin
        win_d[ptr_q] = int_cnt_q;
        sum_d = sum_q - SW'(win_q[ptr_q]) + SW'(int_cnt_q);
        ptr_d = ptr_q + 1'b1;
      end
    end else if (timeout_d) begin
      fill_d = 1'b1;
    end
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      sum_q <= '0;
      ptr_q <= '0;
      fill_q <= 1'b1;
    end else begin
      win_q <= win_d;
      sum_q <= sum_d;
      ptr_q <= ptr_d;
      fill_q <= fill_d;
    end
  end

  assign new_period = CNT_W'(sum_q >> AVG_LOG2);
`else
  logic [CNT_W-1:0] lat_q, lat_d;

  always_comb begin
    lat_d = meas ? int_cnt_q : lat_q;
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) lat_q <= '0;
    else lat_q <= lat_d;
  end

  assign new_period = lat_q;
`endif

  always_comb begin
    period_d = upd_q ? new_period : period_q;
    valid_d = valid_q | upd_q;
    if (acc || period_d != period_q || phase_q >= period_q - 1'b1) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end
    thr_d = CNT_W'((PW'(period_q) * PW'(duty)) >> DUTY_W);
    led_d = phase_q < thr_q;
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q <= '0;
      tap_q <= 1'b0;
      state_q <= IDLE;
      int_cnt_q <= '0;
      tap_pulse_q <= 1'b0;
      timeout_q <= 1'b0;
      upd_q <= 1'b0;
      valid_q <= 1'b0;
      period_q <= DEF_P;
      phase_q <= '0;
      thr_q <= '0;
      led_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      deb_q <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q <= deb_cnt_d;
      tap_q <= tap_d;
      state_q <= state_d;
      int_cnt_q <= int_cnt_d;
      tap_pulse_q <= acc;
      timeout_q <= timeout_d;
      upd_q <= meas;
      valid_q <= valid_d;
      period_q <= period_d;
      phase_q <= phase_d;
      thr_q <= thr_d;
      led_q <= led_d;
    end
  end

  assign led_out = led_q;
  assign tap_pulse = tap_pulse_q;
  assign period_out = period_q;
  assign period_valid = valid_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_tap_tempo_blinker.sv
// Bench for tap_tempo_blinker: directed scenarios plus randomized tap
// sequences checked against an event-level model of tap timing.
module tb_tap_tempo_blinker;
  localparam int CNT_W = 32;
  localparam int DB = 4;
  localparam int DEF_P = 100;
  localparam int MIN_P = 16;
  localparam int MAX_P = 200;
  localparam int AVG = 2;
  localparam int DW = 8;
  // press edge -> tap_pulse visible: 2 sync + DB debounce + edge + pulse reg
  localparam int LAT = DB + 4;

  logic clk48 = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in = 1'b0;
  logic [DW-1:0] duty = 8'd128;
  logic led_out, tap_pulse, period_valid, timeout;
  logic [CNT_W-1:0] period_out;

  tap_tempo_blinker #(
    .CNT_W(CNT_W), .DEBOUNCE_CYC(DB), .DEFAULT_PERIOD(DEF_P),
    .MIN_PERIOD(MIN_P), .MAX_PERIOD(MAX_P), .AVG_LOG2(AVG), .DUTY_W(DW)
  ) dut (
    .clk48(clk48), .rst_n(rst_n), .btn_in(btn_in), .duty(duty),
    .led_out(led_out), .tap_pulse(tap_pulse), .period_out(period_out),
    .period_valid(period_valid), .timeout(timeout)
  );

  always #5 clk48 = ~clk48;

  int cyc = 0;
  always @(posedge clk48) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  int act_tap[$], act_tout[$], chg_cyc[$], chg_val[$];
  bit led_h[int];
  int last_per = DEF_P;
  int gaps_q[$], press_q[$];
  int end_cyc;
  int exp_tap[$], exp_tout[$], exp_chg_cyc[$], exp_chg_val[$];
  int exp_per;
  bit exp_valid;

  always @(negedge clk48) begin
    if (mon_en) begin
      if (tap_pulse) act_tap.push_back(cyc);
      if (timeout) act_tout.push_back(cyc);
      if (int'(period_out) != last_per) begin
        chg_cyc.push_back(cyc);
        chg_val.push_back(int'(period_out));
        last_per = int'(period_out);
      end
      led_h[cyc] = led_out;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    btn_in = 1'b0;
    repeat (2) @(posedge clk48);
    act_tap.delete();
    act_tout.delete();
    chg_cyc.delete();
    chg_val.delete();
    led_h.delete();
    last_per = DEF_P;
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Presses start 3 cycles out, spaced by gaps_q, each held `hold` cycles
  task automatic play(input int hold, input int tail);
    int pt;
    press_q.delete();
    @(posedge clk48); #1;
    pt = cyc + 3;
    press_q.push_back(pt);
    foreach (gaps_q[i]) begin
      pt += gaps_q[i];
      press_q.push_back(pt);
    end
    end_cyc = pt + tail;
    while (cyc < end_cyc) begin
      @(posedge clk48); #1;
      btn_in = 1'b0;
      foreach (press_q[i])
        if (cyc >= press_q[i] && cyc < press_q[i] + hold) btn_in = 1'b1;
    end
  endtask

  // Event-level model: walk taps, apply acceptance/timeout rules
  task automatic model_calc();
    int armed, last, pc, iv, np, sum;
    int win[$];
    exp_tap.delete();
    exp_tout.delete();
    exp_chg_cyc.delete();
    exp_chg_val.delete();
    exp_per = DEF_P;
    exp_valid = 1'b0;
    armed = 0;
    last = 0;
    foreach (press_q[i]) begin
      pc = press_q[i] + LAT;
      if (armed != 0 && pc - last > MAX_P) begin
        exp_tout.push_back(last + MAX_P);
        armed = 0;
        win.delete();
      end
      if (armed == 0) begin
        armed = 1;
        last = pc;
        exp_tap.push_back(pc);
      end else if (pc - last >= MIN_P) begin
        iv = pc - last;
        last = pc;
        exp_tap.push_back(pc);
`ifdef TAP_AVG_EN
        if (win.size() == 0) begin
          for (int k = 0; k < (1 << AVG); k++) win.push_back(iv);
        end else begin
          void'(win.pop_front());
          win.push_back(iv);
        end
        sum = 0;
        foreach (win[k]) sum += win[k];
        np = sum / (1 << AVG);
`else
        sum = 0;
        np = iv;
`endif
        if (np != exp_per) begin
          exp_chg_cyc.push_back(pc + 1);
          exp_chg_val.push_back(np);
        end
        exp_per = np;
        exp_valid = 1'b1;
      end
    end
    if (armed != 0 && last + MAX_P < end_cyc) exp_tout.push_back(last + MAX_P);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    btn_in = 1'b0;
    duty = 8'd128;
    repeat (3) @(posedge clk48);
    #1;
    checks++;
    if (led_out !== 1'b0 || tap_pulse !== 1'b0 || timeout !== 1'b0 || period_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags led=%b tap=%b tout=%b valid=%b required all 0",
               led_out, tap_pulse, timeout, period_valid);
    end
    checks++;
    if (period_out !== CNT_W'(DEF_P)) begin
      failures++;
      $display("FAIL reset_period got=%0d required=%0d", period_out, DEF_P);
    end
  endtask

  task automatic test_default_blink();
    int s, hi, rs;
    do_reset();
    duty = 8'd128;
    repeat (20) @(posedge clk48);
    #1 s = cyc;
    repeat (202) @(posedge clk48);
    #1;
    hi = 0;
    rs = 0;
    for (int c = s; c < s + 200; c++) begin
      hi += int'(led_h[c]);
      if (!led_h[c] && led_h[c+1]) rs++;
    end
    checks++;
    if (hi != 100 || rs != 2) begin
      failures++;
      $display("FAIL default_blink high=%0d rises=%0d required high=100 rises=2", hi, rs);
    end
    checks++;
    if (period_out !== CNT_W'(DEF_P) || period_valid !== 1'b0) begin
      failures++;
      $display("FAIL default_period got=%0d valid=%b required=%0d valid=0",
               period_out, period_valid, DEF_P);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    gaps_q = {};
    play(3, 40);
    checks++;
    if (act_tap.size() != 0 || period_out !== CNT_W'(DEF_P)) begin
      failures++;
      $display("FAIL glitch taps=%0d period=%0d required taps=0 period=%0d",
               act_tap.size(), period_out, DEF_P);
    end
  endtask

  task automatic test_two_taps();
    int t0, t1, c, bad;
    bit e;
    do_reset();
    duty = 8'd128;
    gaps_q = {40};
    play(5, 260);
    t0 = press_q[0] + LAT;
    t1 = press_q[1] + LAT;
    checks++;
    if (act_tap.size() != 2 || act_tap[0] != t0 || act_tap[1] != t1) begin
      failures++;
      $display("FAIL two_taps_pulses count=%0d first=%0d required count=2 at %0d,%0d",
               act_tap.size(), (act_tap.size() > 0) ? act_tap[0] : -1, t0, t1);
    end
    checks++;
    if (chg_cyc.size() != 1 || chg_cyc[0] != t1 + 1 || chg_val[0] != 40) begin
      failures++;
      $display("FAIL two_taps_period_update changes=%0d required one change to 40 at %0d",
               chg_cyc.size(), t1 + 1);
    end
    checks++;
    if (period_out !== CNT_W'(40) || period_valid !== 1'b1) begin
      failures++;
      $display("FAIL two_taps_retained period=%0d valid=%b required 40 valid=1",
               period_out, period_valid);
    end
    checks++;
    if (act_tout.size() != 1 || act_tout[0] != t1 + MAX_P) begin
      failures++;
      $display("FAIL two_taps_timeout count=%0d required one at %0d", act_tout.size(), t1 + MAX_P);
    end
    c = t1 + 1;
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      e = (k % 40) < 20;
      if (led_h[c+1+k] != e) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL two_taps_led_phase wrong_cycles=%0d required 0", bad);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (period_out !== CNT_W'(DEF_P) || period_valid !== 1'b0 || led_out !== 1'b0) begin
      failures++;
      $display("FAIL async_reset period=%0d valid=%b led=%b required %0d,0,0",
               period_out, period_valid, led_out, DEF_P);
    end
  endtask

  task automatic test_ignored();
    do_reset();
    gaps_q = {10};
    play(5, 60);
    checks++;
    if (act_tap.size() != 1 || chg_cyc.size() != 0) begin
      failures++;
      $display("FAIL ignored_tap taps=%0d changes=%0d required taps=1 changes=0",
               act_tap.size(), chg_cyc.size());
    end
    checks++;
    if (period_out !== CNT_W'(DEF_P) || period_valid !== 1'b0) begin
      failures++;
      $display("FAIL ignored_period got=%0d valid=%b required=%0d valid=0",
               period_out, period_valid, DEF_P);
    end
  endtask

  task automatic test_timeout();
    int t0;
    do_reset();
    gaps_q = {};
    play(5, 260);
    t0 = press_q[0] + LAT;
    checks++;
    if (act_tout.size() != 1 || act_tout[0] != t0 + MAX_P) begin
      failures++;
      $display("FAIL timeout_pulse count=%0d first=%0d required one at %0d",
               act_tout.size(), (act_tout.size() > 0) ? act_tout[0] : -1, t0 + MAX_P);
    end
    checks++;
    if (period_out !== CNT_W'(DEF_P) || period_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_period got=%0d valid=%b required=%0d valid=0",
               period_out, period_valid, DEF_P);
    end
  endtask

  task automatic test_avg();
    int t1, t5, hi, v2;
    do_reset();
    duty = 8'd0;
    gaps_q = {40, 40, 40, 40, 80};
    play(5, 100);
    t1 = press_q[1] + LAT;
    t5 = press_q[5] + LAT;
`ifdef TAP_AVG_EN
    v2 = 50;
`else
    v2 = 80;
`endif
    checks++;
    if (chg_cyc.size() != 2 || chg_cyc[0] != t1 + 1 || chg_val[0] != 40) begin
      failures++;
      $display("FAIL avg_first changes=%0d required 40 at %0d", chg_cyc.size(), t1 + 1);
    end
    checks++;
    if (chg_cyc.size() != 2 || chg_cyc[1] != t5 + 1 || chg_val[1] != v2) begin
      failures++;
      $display("FAIL avg_last period=%0d required %0d at %0d", period_out, v2, t5 + 1);
    end
    hi = 0;
    foreach (led_h[c]) hi += int'(led_h[c]);
    checks++;
    if (hi != 0) begin
      failures++;
      $display("FAIL duty_zero led_high_cycles=%0d required 0", hi);
    end
  endtask

  task automatic test_sequences();
    int nb, p, thr, s, hi, rs, r;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      gaps_q = {};
      if (it == 0) begin
        duty = 8'd128;
        gaps_q = {16, 200, 201, 15, 30};
      end else begin
        duty = 8'($urandom_range(0, 255));
        for (int g = 0; g < 6; g++) begin
          r = int'($urandom_range(0, 9));
          if (r < 2) gaps_q.push_back(int'($urandom_range(10, 15)));
          else if (r < 8) gaps_q.push_back(int'($urandom_range(16, 200)));
          else gaps_q.push_back(int'($urandom_range(201, 240)));
        end
      end
      play(5, 260);
      model_calc();
      nb = 0;
      if (act_tap.size() != exp_tap.size()) nb++;
      for (int i = 0; i < act_tap.size() && i < exp_tap.size(); i++)
        if (act_tap[i] != exp_tap[i]) nb++;
      checks++;
      if (nb != 0) begin
        failures++;
        $display("FAIL seq%0d_taps got=%0d required=%0d bad=%0d",
                 it, act_tap.size(), exp_tap.size(), nb);
      end
      nb = 0;
      if (act_tout.size() != exp_tout.size()) nb++;
      for (int i = 0; i < act_tout.size() && i < exp_tout.size(); i++)
        if (act_tout[i] != exp_tout[i]) nb++;
      checks++;
      if (nb != 0) begin
        failures++;
        $display("FAIL seq%0d_timeouts got=%0d required=%0d bad=%0d",
                 it, act_tout.size(), exp_tout.size(), nb);
      end
      nb = 0;
      if (chg_cyc.size() != exp_chg_cyc.size()) nb++;
      for (int i = 0; i < chg_cyc.size() && i < exp_chg_cyc.size(); i++)
        if (chg_cyc[i] != exp_chg_cyc[i] || chg_val[i] != exp_chg_val[i]) nb++;
      checks++;
      if (nb != 0) begin
        failures++;
        $display("FAIL seq%0d_period_updates got=%0d required=%0d bad=%0d",
                 it, chg_cyc.size(), exp_chg_cyc.size(), nb);
      end
      checks++;
      if (period_out !== CNT_W'(exp_per) || period_valid !== exp_valid) begin
        failures++;
        $display("FAIL seq%0d_period got=%0d valid=%b required=%0d valid=%b",
                 it, period_out, period_valid, exp_per, exp_valid);
      end
      p = exp_per;
      thr = (p * int'(duty)) / 256;
      s = end_cyc - p - 3;
      hi = 0;
      rs = 0;
      for (int c = s; c < s + p; c++) begin
        hi += int'(led_h[c]);
        if (!led_h[c] && led_h[c+1]) rs++;
      end
      checks++;
      if (hi != thr || rs != ((thr > 0) ? 1 : 0)) begin
        failures++;
        $display("FAIL seq%0d_duty high=%0d rises=%0d required high=%0d (duty=%0d period=%0d)",
                 it, hi, rs, thr, duty, p);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_blink();
    test_glitch();
    test_two_taps();
    test_ignored();
    test_timeout();
    test_avg();
    test_sequences();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
